toy_trap_ctrl: RTL and testbench



---
 rtl/toy_trap_ctrl.sv | 151 +++++++++++++++
 tb/tb_toy_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_trap_ctrl.sv
// Trap/xRET/WFI sequencer: CSR update or return strobe, then a front-end redirect.
// Optional vectored interrupt targets: define TOY_TRAP_VECTORED_EN.
module toy_trap_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned INST_W         = 32,
  parameter logic [31:0] DEBUG_ENTRY_PC = 32'h0000_0800,
  parameter logic [31:0] DEBUG_HALT_REQ = 32'h0000_0018
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spu_jump_vld,
  input  logic [1:0]        spu_jump_op,
  input  logic [31:0]       spu_trap_cause,
  input  logic [ADDR_W-1:0] spu_trap_pc,
  input  logic [INST_W-1:0] spu_trap_inst,
  input  logic              spu_wfi_vld,
  input  logic [31:0]       csr_mtvec,
  input  logic [ADDR_W-1:0] csr_mepc,
  input  logic [ADDR_W-1:0] csr_sepc,
  input  logic [ADDR_W-1:0] csr_dpc,
  input  logic              irq_pending,
  output logic              trap_csr_wr_vld,
  output logic [1:0]        trap_csr_op,
  output logic [ADDR_W-1:0] trap_epc,
  output logic [31:0]       trap_cause,
  output logic [31:0]       trap_tval,
  output logic              ret_vld,
  output logic [1:0]        ret_op,
  output logic              redirect_vld,
  input  logic              redirect_rdy,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic              wfi_halt,
  output logic              busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StTrapWr = 3'd1;
  localparam logic [2:0] StRet    = 3'd2;
  localparam logic [2:0] StRedir  = 3'd3;
  localparam logic [2:0] StWfi    = 3'd4;

  localparam logic [31:0] McauseIllegalInstr = 32'd2;
  localparam logic [31:0] McauseBreak        = 32'd3;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       cause_q;
  logic [INST_W-1:0] inst_q;
  logic [1:0]        op_q;
  logic              debug_q;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [ADDR_W-1:0] trap_target;
  logic              unused_bits;

  assign unused_bits = ^csr_mtvec;

  always_comb begin
    trap_target = {csr_mtvec[ADDR_W-1:2], 2'b00};
`ifdef TOY_TRAP_VECTORED_EN
    if (csr_mtvec[1:0] == 2'b01 && cause_q[31]) begin
      trap_target = trap_target + ADDR_W'({cause_q[5:0], 2'b00});
    end
`endif
    if (debug_q) begin
      trap_target = ADDR_W'(DEBUG_ENTRY_PC);
    end
  end

  always_comb begin
    state_d    = state_q;
    redir_pc_d = redir_pc_q;
    case (state_q)
      StIdle: begin
        // A jump in the same cycle as WFI wins; the WFI is dropped.
        if (spu_jump_vld) begin
          state_d = (spu_jump_op == 2'b11) ? StTrapWr : StRet;
        end else if (spu_wfi_vld) begin
          state_d = StWfi;
        end
      end
      StTrapWr: begin
        redir_pc_d = trap_target;
        state_d    = StRedir;
      end
      StRet: begin
        // Return CSRs are sampled now, before the CSR unit acts on ret_vld.
        case (op_q)
          2'b00:   redir_pc_d = csr_sepc;
          2'b10:   redir_pc_d = csr_dpc;
          default: redir_pc_d = csr_mepc;
        endcase
        state_d = StRedir;
      end
      StRedir: if (redirect_rdy) state_d = StIdle;
      StWfi:   if (irq_pending) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      cause_q    <= '0;
      inst_q     <= '0;
      op_q       <= '0;
      debug_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      if (state_q == StIdle && spu_jump_vld) begin
        op_q <= spu_jump_op;
        if (spu_jump_op == 2'b11) begin
          pc_q    <= spu_trap_pc;
          cause_q <= spu_trap_cause;
          inst_q  <= spu_trap_inst;
          debug_q <= (spu_trap_cause == DEBUG_HALT_REQ);
        end
      end
    end
  end

  always_comb begin
    trap_csr_wr_vld = (state_q == StTrapWr);
    trap_csr_op     = 2'b00;
    trap_epc        = '0;
    trap_cause      = '0;
    trap_tval       = '0;
    if (trap_csr_wr_vld) begin
      trap_csr_op = debug_q ? 2'b10 : 2'b01;
      trap_epc    = pc_q;
      trap_cause  = cause_q;
      if (cause_q == McauseIllegalInstr) begin
        trap_tval = 32'(inst_q);
      end else if (cause_q == McauseBreak) begin
        trap_tval = 32'(pc_q);
      end
    end
  end

  assign ret_vld      = (state_q == StRet);
  assign ret_op       = ret_vld ? op_q : 2'b00;
  assign redirect_vld = (state_q == StRedir);
  assign flush        = redirect_vld;
  assign redirect_pc  = redir_pc_q;
  assign wfi_halt     = (state_q == StWfi);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_toy_trap_ctrl.sv
// Directed bench for toy_trap_ctrl: trap entry, xRET, debug, WFI, vectoring and reset.
module tb_toy_trap_ctrl;

  localparam logic [31:0] DebugHaltReq = 32'h0000_0018;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spu_jump_vld;
  logic [1:0]  spu_jump_op;
  logic [31:0] spu_trap_cause;
  logic [31:0] spu_trap_pc;
  logic [31:0] spu_trap_inst;
  logic        spu_wfi_vld;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_sepc;
  logic [31:0] csr_dpc;
  logic        irq_pending;
  logic        trap_csr_wr_vld;
  logic [1:0]  trap_csr_op;
  logic [31:0] trap_epc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        ret_vld;
  logic [1:0]  ret_op;
  logic        redirect_vld;
  logic        redirect_rdy;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        wfi_halt;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int halt_cycles;

  toy_trap_ctrl #(
    .ADDR_W         (32),
    .INST_W         (32),
    .DEBUG_ENTRY_PC (32'h0000_0800),
    .DEBUG_HALT_REQ (DebugHaltReq)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .spu_jump_vld    (spu_jump_vld),
    .spu_jump_op     (spu_jump_op),
    .spu_trap_cause  (spu_trap_cause),
    .spu_trap_pc     (spu_trap_pc),
    .spu_trap_inst   (spu_trap_inst),
    .spu_wfi_vld     (spu_wfi_vld),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .csr_sepc        (csr_sepc),
    .csr_dpc         (csr_dpc),
    .irq_pending     (irq_pending),
    .trap_csr_wr_vld (trap_csr_wr_vld),
    .trap_csr_op     (trap_csr_op),
    .trap_epc        (trap_epc),
    .trap_cause      (trap_cause),
    .trap_tval       (trap_tval),
    .ret_vld         (ret_vld),
    .ret_op          (ret_op),
    .redirect_vld    (redirect_vld),
    .redirect_rdy    (redirect_rdy),
    .redirect_pc     (redirect_pc),
    .flush           (flush),
    .wfi_halt        (wfi_halt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Upstream contract: nothing is issued while the controller is busy.
  always @(posedge clk) begin
    if (rst_n && busy) begin
      assert (!spu_jump_vld && !spu_wfi_vld) else $error("upstream issued while busy");
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_jump(input logic [1:0] op, input logic [31:0] cause,
                            input logic [31:0] pc, input logic [31:0] inst);
    spu_jump_vld   = 1'b1;
    spu_jump_op    = op;
    spu_trap_cause = cause;
    spu_trap_pc    = pc;
    spu_trap_inst  = inst;
    tick();
    spu_jump_vld   = 1'b0;
    spu_wfi_vld    = 1'b0;
  endtask

  task automatic accept_redirect();
    redirect_rdy = 1'b1;
    tick();
    redirect_rdy = 1'b0;
    check("idle_after_redirect", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    spu_jump_vld = 1'b0; spu_jump_op = 2'b00; spu_trap_cause = '0;
    spu_trap_pc = '0; spu_trap_inst = '0; spu_wfi_vld = 1'b0;
    csr_mtvec = 32'h8000_0000; csr_mepc = '0; csr_sepc = '0; csr_dpc = '0;
    irq_pending = 1'b0; redirect_rdy = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_redir_vld", {31'd0, redirect_vld}, 32'd0);
    check("rst_csr_wr", {31'd0, trap_csr_wr_vld}, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    // Illegal instruction trap.
    issue_jump(2'b11, 32'd2, 32'h100, 32'hFFFF_FFFF);
    check("ill_wr_vld", {31'd0, trap_csr_wr_vld}, 32'd1);
    check("ill_csr_op", {30'd0, trap_csr_op}, 32'd1);
    check("ill_epc", trap_epc, 32'h100);
    check("ill_cause", trap_cause, 32'd2);
    check("ill_tval", trap_tval, 32'hFFFF_FFFF);
    check("ill_no_redir_yet", {31'd0, redirect_vld}, 32'd0);
    tick();
    check("ill_wr_pulse", {31'd0, trap_csr_wr_vld}, 32'd0);
    check("ill_redir_vld", {31'd0, redirect_vld}, 32'd1);
    check("ill_flush", {31'd0, flush}, 32'd1);
    check("ill_redir_pc", redirect_pc, 32'h8000_0000);
    accept_redirect();

    // mret with the front end stalling the redirect for 3 cycles.
    csr_mepc = 32'h240; csr_sepc = 32'h114; csr_dpc = 32'h300;
    issue_jump(2'b01, 32'd0, 32'd0, 32'd0);
    check("mret_ret_vld", {31'd0, ret_vld}, 32'd1);
    check("mret_ret_op", {30'd0, ret_op}, 32'd1);
    check("mret_no_csr_wr", {31'd0, trap_csr_wr_vld}, 32'd0);
    tick();
    csr_mepc = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      check("mret_hold_vld", {31'd0, redirect_vld}, 32'd1);
      check("mret_hold_pc", redirect_pc, 32'h240);
      check("mret_hold_busy", {31'd0, busy}, 32'd1);
      check("mret_hold_ret", {31'd0, ret_vld}, 32'd0);
      tick();
    end
    accept_redirect();

    // sret selects sepc.
    issue_jump(2'b00, 32'd0, 32'd0, 32'd0);
    check("sret_ret_op", {30'd0, ret_op}, 32'd0);
    tick();
    check("sret_redir_pc", redirect_pc, 32'h114);
    accept_redirect();

    // Breakpoint: tval carries the pc.
    issue_jump(2'b11, 32'd3, 32'h500, 32'h0010_0073);
    check("brk_tval", trap_tval, 32'h500);
    tick();
    accept_redirect();

    // Debug halt entry then dret.
    issue_jump(2'b11, DebugHaltReq, 32'h300, 32'h1234_5678);
    check("dbg_csr_op", {30'd0, trap_csr_op}, 32'd2);
    check("dbg_epc", trap_epc, 32'h300);
    check("dbg_tval", trap_tval, 32'd0);
    tick();
    check("dbg_redir_pc", redirect_pc, 32'h800);
    accept_redirect();
    issue_jump(2'b10, 32'd0, 32'd0, 32'd0);
    check("dret_ret_op", {30'd0, ret_op}, 32'd2);
    tick();
    check("dret_redir_pc", redirect_pc, 32'h300);
    accept_redirect();

    // WFI with irq raised in the fifth halted cycle.
    spu_wfi_vld = 1'b1;
    tick();
    spu_wfi_vld = 1'b0;
    halt_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (!wfi_halt) break;
      halt_cycles++;
      if (halt_cycles == 5) irq_pending = 1'b1;
      tick();
    end
    irq_pending = 1'b0;
    check("wfi_halt_cycles", halt_cycles, 32'd5);
    check("wfi_exit_idle", {31'd0, busy}, 32'd0);

    // irq already pending on entry: a single halted cycle.
    irq_pending = 1'b1; spu_wfi_vld = 1'b1;
    tick();
    spu_wfi_vld = 1'b0;
    check("wfi_pend_halt", {31'd0, wfi_halt}, 32'd1);
    tick();
    irq_pending = 1'b0;
    check("wfi_pend_exit", {31'd0, wfi_halt}, 32'd0);

    // Jump and WFI together: the trap wins.
    spu_wfi_vld = 1'b1;
    issue_jump(2'b11, 32'd11, 32'h600, 32'd0);
    check("both_trap_wr", {31'd0, trap_csr_wr_vld}, 32'd1);
    check("both_no_halt", {31'd0, wfi_halt}, 32'd0);
    tick();
    check("both_no_halt2", {31'd0, wfi_halt}, 32'd0);
    accept_redirect();

    // Interrupt cause with vectored mtvec.
    csr_mtvec = 32'h8000_0001;
    issue_jump(2'b11, 32'h8000_0007, 32'h700, 32'd0);
    check("vec_cause", trap_cause, 32'h8000_0007);
    tick();
`ifdef TOY_TRAP_VECTORED_EN
    check("vec_redir_pc", redirect_pc, 32'h8000_001C);
`else
    check("vec_redir_pc", redirect_pc, 32'h8000_0000);
`endif
    accept_redirect();
    csr_mtvec = 32'h8000_0000;

    // Synchronous reset while the redirect is stalled.
    issue_jump(2'b11, 32'd11, 32'h900, 32'd0);
    tick();
    check("pre_rst_redir", {31'd0, redirect_vld}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_redir_vld", {31'd0, redirect_vld}, 32'd0);
    check("mid_rst_flush", {31'd0, flush}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_redir_pc", redirect_pc, 32'd0);
    check("mid_rst_csr_wr", {31'd0, trap_csr_wr_vld}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ecall after reset.
    issue_jump(2'b11, 32'd11, 32'h400, 32'h0000_0073);
    check("ecall_wr_vld", {31'd0, trap_csr_wr_vld}, 32'd1);
    check("ecall_epc", trap_epc, 32'h400);
    check("ecall_tval", trap_tval, 32'd0);
    tick();
    check("ecall_redir_pc", redirect_pc, 32'h8000_0000);
    accept_redirect();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
